// File: rtl/ebi_master_pkg.sv
// Shared definitions for the external bus interface master.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
// Contents: FSM state enum, transaction-source enum, bus widths and the
// fixed slave register map used by the command burst and status read.
package ebi_master_pkg;

    localparam int ADDR_W = 19;
    localparam int DATA_W = 16;
    localparam int CMD_W  = 80;
    localparam int CNT_W  = 4;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETUP,
        ST_STROBE,
        ST_HOLD
    } ebi_state_e;

    typedef enum logic [1:0] {
        SRC_REQ,
        SRC_CMD,
        SRC_STAT
    } ebi_src_e;

    // Slave register map.
    localparam logic [ADDR_W-1:0] STATUS      = 19'd0;
    localparam logic [ADDR_W-1:0] CMD_WRD_1   = 19'd1;
    localparam logic [ADDR_W-1:0] CMD_WRD_2   = 19'd2;
    localparam logic [ADDR_W-1:0] CMD_WRD_3   = 19'd3;
    localparam logic [ADDR_W-1:0] CMD_WRD_4   = 19'd4;
    localparam logic [ADDR_W-1:0] CMD_WRD_5   = 19'd5;
    localparam logic [ADDR_W-1:0] NEXT_SAMPLE = 19'd6;
    localparam logic [ADDR_W-1:0] RESET_TIME  = 19'd7;
    localparam logic [ADDR_W-1:0] RUN_TIME    = 19'd8;

    // A phase lasting n cycles is timed by loading n-1 and leaving at zero.
    function automatic logic [CNT_W-1:0] phase_load(input int n);
        return CNT_W'(n - 1);
    endfunction

endpackage

// File: rtl/ebi_phase_timer.sv
// Phase timer: 4-bit down counter, loaded on phase entry, terminal count at 0.
// Latency: tc_o is high in the cycle after a load of 0; a load of N-1 gives N cycles.
// Backpressure: none; saturates at 0 instead of wrapping.
// Ports: clk/rst_n, load_i + load_val_i (reload), tc_o (counter is zero).
module ebi_phase_timer
    import ebi_master_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_i,
    input  logic [CNT_W-1:0] load_val_i,
    output logic             tc_o
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tc_o = (cnt_q == '0);

endmodule

// File: rtl/ebi_master.sv
// External bus master: single reads/writes, 5-word command bursts, irq status reads.
// Latency: SETUP_CYC + STROBE_CYC + HOLD_CYC cycles from acceptance back to IDLE.
// Backpressure: req_ready/cmd_ready pulse only in the IDLE cycle a request is taken.
// Ports: req_* single-word requests, cmd_* burst requests, rsp_* read data,
// irq/status_* interrupt-driven status reads, ebi_* external bus pins.
module ebi_master
    import ebi_master_pkg::*;
#(
    parameter int SETUP_CYC  = 1,
    parameter int STROBE_CYC = 4,
    parameter int HOLD_CYC   = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [CMD_W-1:0]  cmd_data,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    input  logic              irq,
    output logic              status_valid,
    output logic [DATA_W-1:0] status,
    output logic              ebi_cs,
    output logic              ebi_rd,
    output logic              ebi_wr,
    output logic [ADDR_W-1:0] ebi_addr,
    output logic [DATA_W-1:0] ebi_dout,
    input  logic [DATA_W-1:0] ebi_din
);

    localparam logic [CNT_W-1:0] SETUP_LD  = phase_load(SETUP_CYC);
    localparam logic [CNT_W-1:0] STROBE_LD = phase_load(STROBE_CYC);
    localparam logic [CNT_W-1:0] HOLD_LD   = phase_load(HOLD_CYC);

    ebi_state_e        state_q;
    ebi_src_e          src_q;
    logic              is_wr_q;
    logic              armed_q;
    logic              irq_q;
    logic              pend_q;
    logic [63:0]       burst_q;     // remaining command words, next one in [63:48]
    logic              cs_q, rd_q, wr_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] dout_q;
    logic              rsp_valid_q;
    logic [DATA_W-1:0] rsp_rdata_q;
    logic              status_valid_q;
    logic [DATA_W-1:0] status_q;

    logic              in_idle;
    logic              cmd_go, req_go, stat_go, any_go;
    logic              irq_rise;
    logic              tmr_load;
    logic [CNT_W-1:0]  tmr_val;
    logic              tmr_tc;

    // armed_q stays low during reset and for the first edge after release, so
    // the handshakes are forced low asynchronously and nothing is accepted
    // before the second clock edge.
    assign in_idle  = armed_q && (state_q == ST_IDLE);
    assign cmd_go   = in_idle && cmd_valid;
    assign req_go   = in_idle && req_valid && !cmd_valid;
    assign stat_go  = in_idle && pend_q && !cmd_valid && !req_valid;
    assign any_go   = cmd_go || req_go || stat_go;
    assign irq_rise = irq && !irq_q;

    assign cmd_ready = cmd_go;
    assign req_ready = req_go;

    // Reload the timer on entry to each phase with that phase's length.
    always_comb begin
        tmr_load = 1'b0;
        tmr_val  = SETUP_LD;
        unique case (state_q)
            ST_IDLE:   tmr_load = any_go;
            ST_SETUP:  begin tmr_load = tmr_tc; tmr_val = STROBE_LD; end
            ST_STROBE: begin tmr_load = tmr_tc; tmr_val = HOLD_LD;   end
            ST_HOLD:   begin tmr_load = tmr_tc; tmr_val = SETUP_LD;  end
            default:   tmr_load = 1'b0;
        endcase
    end

    ebi_phase_timer u_timer (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_i     (tmr_load),
        .load_val_i (tmr_val),
        .tc_o       (tmr_tc)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= ST_IDLE;
            src_q          <= SRC_REQ;
            is_wr_q        <= 1'b0;
            armed_q        <= 1'b0;
            irq_q          <= 1'b0;
            pend_q         <= 1'b0;
            burst_q        <= '0;
            cs_q           <= 1'b0;
            rd_q           <= 1'b0;
            wr_q           <= 1'b0;
            addr_q         <= '0;
            dout_q         <= '0;
            rsp_valid_q    <= 1'b0;
            rsp_rdata_q    <= '0;
            status_valid_q <= 1'b0;
            status_q       <= '0;
        end else begin
            armed_q        <= 1'b1;
            irq_q          <= irq;
            // A new edge wins over the clear, so an edge coinciding with the
            // status acceptance is not lost; edges while pending just merge.
            pend_q         <= (pend_q && !stat_go) || irq_rise;
            rsp_valid_q    <= 1'b0;
            status_valid_q <= 1'b0;

            unique case (state_q)
                ST_IDLE: begin
                    if (cmd_go) begin
                        state_q <= ST_SETUP;
                        src_q   <= SRC_CMD;
                        is_wr_q <= 1'b1;
                        cs_q    <= 1'b1;
                        addr_q  <= CMD_WRD_1;
                        dout_q  <= cmd_data[79:64];
                        burst_q <= cmd_data[63:0];
                    end else if (req_go) begin
                        state_q <= ST_SETUP;
                        src_q   <= SRC_REQ;
                        is_wr_q <= req_write;
                        cs_q    <= 1'b1;
                        addr_q  <= req_addr;
                        dout_q  <= req_wdata;
                    end else if (stat_go) begin
                        state_q <= ST_SETUP;
                        src_q   <= SRC_STAT;
                        is_wr_q <= 1'b0;
                        cs_q    <= 1'b1;
                        addr_q  <= STATUS;
                    end
                end
                ST_SETUP: begin
                    if (tmr_tc) begin
                        state_q <= ST_STROBE;
                        rd_q    <= !is_wr_q;
                        wr_q    <= is_wr_q;
                    end
                end
                ST_STROBE: begin
                    if (tmr_tc) begin
                        state_q <= ST_HOLD;
                        cs_q    <= 1'b0;
                        rd_q    <= 1'b0;
                        wr_q    <= 1'b0;
                        if (!is_wr_q) begin
                            if (src_q == SRC_STAT) begin
                                status_valid_q <= 1'b1;
                                status_q       <= ebi_din;
                            end else begin
                                rsp_valid_q <= 1'b1;
                                rsp_rdata_q <= ebi_din;
                            end
                        end
                    end
                end
                ST_HOLD: begin
                    if (tmr_tc) begin
                        // Bursts run straight through to the last word, so no
                        // other source can get in between.
                        if ((src_q == SRC_CMD) && (addr_q != CMD_WRD_5)) begin
                            state_q <= ST_SETUP;
                            cs_q    <= 1'b1;
                            addr_q  <= addr_q + 1'b1;
                            dout_q  <= burst_q[63:48];
                            burst_q <= {burst_q[47:0], 16'h0000};
                        end else begin
                            state_q <= ST_IDLE;
                        end
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign ebi_cs       = cs_q;
    assign ebi_rd       = rd_q;
    assign ebi_wr       = wr_q;
    assign ebi_addr     = addr_q;
    assign ebi_dout     = dout_q;
    assign rsp_valid    = rsp_valid_q;
    assign rsp_rdata    = rsp_rdata_q;
    assign status_valid = status_valid_q;
    assign status       = status_q;

endmodule
